// File: rtl/mux_pipe_n.sv
// mux_pipe_n: NUM_CH-way data multiplexer with an optional registered select,
// PIPE output register stages, a valid pipeline that tracks the data path, and
// a sticky flag raised when a qualified sample uses an out-of-range select.
module mux_pipe_n #(
    parameter int DATA_WIDTH = 18,
    parameter int NUM_CH     = 4,
    parameter int SEL_REG    = 1,
    parameter int PIPE       = 1,
    localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [SEL_W-1:0]             sel,
    input  logic [NUM_CH*DATA_WIDTH-1:0] x,
    input  logic                         in_valid,
    input  logic                         clr_err,
    output logic [DATA_WIDTH-1:0]        y,
    output logic                         out_valid,
    output logic                         sel_err
);

    // A power-of-two channel count leaves no unused select codes.
    localparam bit POW2 = (NUM_CH == (1 << SEL_W));

    logic [SEL_W-1:0]      sel_e;
    logic [DATA_WIDTH-1:0] mux_y;
    logic                  sel_oor;

    // ------------------------------------------------------------------
    // Effective select: registered (one extra cycle of sel latency) or direct
    // ------------------------------------------------------------------
    if (SEL_REG != 0) begin : g_sel_reg
        logic [SEL_W-1:0] sel_q;
        logic [SEL_W-1:0] sel_d;

        // Next select value: load on enabled edges, otherwise hold.
        always_comb begin
            sel_d = ce ? sel : sel_q;
        end

        // Select register.
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) sel_q <= '0;
            else     sel_q <= sel_d;
        end

        assign sel_e = sel_q;
    end else begin : g_sel_comb
        assign sel_e = sel;
    end

    assign sel_oor = !POW2 && (int'(sel_e) >= NUM_CH);

    // Channel selection; unused select codes produce all zeros.
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    always_comb begin
        mux_y = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_e == SEL_W'(k)) mux_y = x[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline: data and valid advance together, only when ce=1
    // ------------------------------------------------------------------
    if (PIPE > 0) begin : g_pipe
        logic [DATA_WIDTH-1:0] data_q [PIPE];
        logic [DATA_WIDTH-1:0] data_d [PIPE];
        logic [PIPE-1:0]       vld_q;
        logic [PIPE-1:0]       vld_d;

        // Shift the data/valid stages by one position on enabled edges.
        always_comb begin
            data_d = data_q;
            vld_d  = vld_q;
            if (ce) begin
                data_d[0] = mux_y;
                vld_d[0]  = in_valid;
                for (int i = 1; i < PIPE; i++) begin
                    data_d[i] = data_q[i-1];
                    vld_d[i]  = vld_q[i-1];
                end
            end
        end

        // Pipeline registers.
        // NOTE: the data stages are reset along with the valid bits because y
        // must read zero during reset, not just be qualified off.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < PIPE; i++) data_q[i] <= '0;
                vld_q <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign y         = data_q[PIPE-1];
        assign out_valid = vld_q[PIPE-1];
    end else begin : g_no_pipe
        assign y         = mux_y;
        assign out_valid = in_valid;
    end

    // ------------------------------------------------------------------
    // Sticky out-of-range flag; clear is independent of ce, set wins
    // ------------------------------------------------------------------
    logic sel_err_q;
    logic sel_err_d;

    // Next flag value: clear request first, then a set overrides it.
    always_comb begin
        sel_err_d = sel_err_q;
        if (clr_err) sel_err_d = 1'b0;
        if (ce && in_valid && sel_oor) sel_err_d = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_err_q <= 1'b0;
        else     sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Testbench for mux_pipe_n: directed scenarios on five fixed configurations,
// then a randomized sweep over nine configurations, each checked by a
// scoreboard fed from a transaction-level reference model.
module tb_mux_pipe_n;

    localparam int N_RAND = 10000;
    localparam int N_CFG  = 9;
    localparam int CFG_NC   [N_CFG] = '{2, 2, 2, 3, 3, 3, 16, 16, 16};
    localparam int CFG_DW   [N_CFG] = '{1, 18, 48, 1, 18, 48, 1, 18, 48};
    localparam int CFG_PIPE [N_CFG] = '{0, 1, 2, 3, 0, 1, 3, 2, 0};
    localparam int CFG_SR   [N_CFG] = '{1, 0, 1, 0, 0, 1, 1, 0, 1};

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    logic rand_go;
    int   n_cmp;
    int   n_fail;
    int   rnd_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed instances ----------------
    // defaults: DW=18, NC=4, SEL_REG=1, PIPE=1
    logic        d_ce, d_iv, d_clr, d_ov, d_err;
    logic [1:0]  d_sel;
    logic [71:0] d_x;
    logic [17:0] d_y;
    mux_pipe_n u_def (
        .clk(clk), .rst(rst), .ce(d_ce), .sel(d_sel), .x(d_x), .in_valid(d_iv),
        .clr_err(d_clr), .y(d_y), .out_valid(d_ov), .sel_err(d_err)
    );

    logic        p3_ce, p3_iv, p3_clr, p3_ov, p3_err;
    logic [1:0]  p3_sel;
    logic [71:0] p3_x;
    logic [17:0] p3_y;
    mux_pipe_n #(.PIPE(3)) u_p3 (
        .clk(clk), .rst(rst), .ce(p3_ce), .sel(p3_sel), .x(p3_x), .in_valid(p3_iv),
        .clr_err(p3_clr), .y(p3_y), .out_valid(p3_ov), .sel_err(p3_err)
    );

    logic        n5_ce, n5_iv, n5_clr, n5_ov, n5_err;
    logic [2:0]  n5_sel;
    logic [89:0] n5_x;
    logic [17:0] n5_y;
    mux_pipe_n #(.NUM_CH(5), .SEL_REG(0)) u_n5 (
        .clk(clk), .rst(rst), .ce(n5_ce), .sel(n5_sel), .x(n5_x), .in_valid(n5_iv),
        .clr_err(n5_clr), .y(n5_y), .out_valid(n5_ov), .sel_err(n5_err)
    );

    logic        p2_ce, p2_iv, p2_clr, p2_ov, p2_err;
    logic [1:0]  p2_sel;
    logic [71:0] p2_x;
    logic [17:0] p2_y;
    mux_pipe_n #(.PIPE(2)) u_p2 (
        .clk(clk), .rst(rst), .ce(p2_ce), .sel(p2_sel), .x(p2_x), .in_valid(p2_iv),
        .clr_err(p2_clr), .y(p2_y), .out_valid(p2_ov), .sel_err(p2_err)
    );

    logic        p0_ce, p0_iv, p0_clr, p0_ov, p0_err;
    logic [1:0]  p0_sel;
    logic [71:0] p0_x;
    logic [17:0] p0_y;
    mux_pipe_n #(.PIPE(0), .SEL_REG(0)) u_p0 (
        .clk(clk), .rst(rst), .ce(p0_ce), .sel(p0_sel), .x(p0_x), .in_valid(p0_iv),
        .clr_err(p0_clr), .y(p0_y), .out_valid(p0_ov), .sel_err(p0_err)
    );

    // ---------------- randomized sweep ----------------
    for (genvar g = 0; g < N_CFG; g++) begin : g_rnd
        localparam int NC = CFG_NC[g];
        localparam int DW = CFG_DW[g];
        localparam int P  = CFG_PIPE[g];
        localparam int SR = CFG_SR[g];
        localparam int SW = (NC > 1) ? $clog2(NC) : 1;

        logic             r_ce, r_iv, r_clr, r_ov, r_err;
        logic [SW-1:0]    r_sel;
        logic [NC*DW-1:0] r_x;
        logic [DW-1:0]    r_y;

        mux_pipe_n #(.DATA_WIDTH(DW), .NUM_CH(NC), .SEL_REG(SR), .PIPE(P)) u_dut (
            .clk(clk), .rst(rst), .ce(r_ce), .sel(r_sel), .x(r_x), .in_valid(r_iv),
            .clr_err(r_clr), .y(r_y), .out_valid(r_ov), .sel_err(r_err)
        );

        // Reference model state: select seen by the mux, sticky flag, and the
        // number of enabled edges so far (the time base for latency).
        exp_t          q[$];
        exp_t          mon_e;
        logic [SW-1:0] m_sel_q;
        logic [SW-1:0] se;
        logic          m_err;
        logic          run;
        int            ce_cnt;
        logic [1023:0] wide;
        logic [63:0]   exp_d;

        initial begin : stim
            r_ce = 1'b0; r_iv = 1'b0; r_clr = 1'b0; r_sel = '0; r_x = '0;
            m_sel_q = '0; m_err = 1'b0; ce_cnt = 0; run = 1'b0;
            wait (rand_go);
            @(posedge clk);
            #1;
            run = 1'b1;
            for (int c = 0; c < N_RAND; c++) begin
                for (int w = 0; w < (NC*DW + 31) / 32; w++) wide[w*32 +: 32] = $urandom;
                r_x   = wide[NC*DW-1:0];
                r_sel = SW'($urandom);
                r_ce  = ($urandom_range(0, 3) != 0);
                r_iv  = ($urandom_range(0, 4) < 3);
                r_clr = ($urandom_range(0, 9) == 0);
                se = (SR != 0) ? m_sel_q : r_sel;
                if (r_ce && r_iv) begin
                    exp_d = '0;
                    for (int k = 0; k < NC; k++)
                        if (int'(se) == k) exp_d = 64'(r_x[k*DW +: DW]);
                    q.push_back('{data: exp_d, due: ce_cnt + P});
                end
                @(posedge clk);
                if (r_ce && r_iv && (int'(se) >= NC)) m_err = 1'b1;
                else if (r_clr)                       m_err = 1'b0;
                if (r_ce) begin
                    m_sel_q = r_sel;
                    ce_cnt++;
                end
                #1;
            end
            r_ce = 1'b0; r_iv = 1'b0; r_clr = 1'b0;
            @(negedge clk);
            run = 1'b0;
            check($sformatf("rnd%0d_inflight", g), 64'(q.size() <= P), 64'd1);
            rnd_done++;
        end

        // Monitor: a valid output is consumed on the last cycle it is held,
        // i.e. a cycle with ce=1 just before the pipeline replaces it.
        always @(negedge clk) begin
            if (run) begin
                check($sformatf("rnd%0d_sel_err", g), 64'(r_err), 64'(m_err));
                if (r_ce && r_ov) begin
                    if (q.size() == 0) begin
                        check($sformatf("rnd%0d_spurious_valid", g), 64'd1, 64'd0);
                    end else begin
                        mon_e = q.pop_front();
                        check($sformatf("rnd%0d_y", g), 64'(r_y), mon_e.data);
                        check($sformatf("rnd%0d_latency", g), 64'(ce_cnt), 64'(mon_e.due));
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [17:0] ep0;
        n_cmp = 0; n_fail = 0; rnd_done = 0; rand_go = 1'b0;
        d_ce = 0;  d_iv = 0;  d_clr = 0;  d_sel = '0;  d_x = '0;
        p3_ce = 0; p3_iv = 0; p3_clr = 0; p3_sel = '0; p3_x = '0;
        n5_ce = 0; n5_iv = 0; n5_clr = 0; n5_sel = '0; n5_x = '0;
        p2_ce = 0; p2_iv = 0; p2_clr = 0; p2_sel = '0; p2_x = '0;
        p0_ce = 0; p0_iv = 0; p0_clr = 0; p0_sel = '0; p0_x = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_y", 64'(d_y), 64'd0);
        check("rst_out_valid", 64'(d_ov), 64'd0);
        check("rst_sel_err", 64'(d_err), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Defaults: select steps 0..3, two cycles sel->y, one cycle valid.
        d_x = {18'd4, 18'd3, 18'd2, 18'd1};
        d_ce = 1'b1; d_sel = 2'd2;
        tick(); tick();
        check("def_pre_y", 64'(d_y), 64'd3);
        check("def_pre_ov", 64'(d_ov), 64'd0);
        d_iv = 1'b1; d_sel = 2'd0;
        tick();
        check("def_ov_after_1", 64'(d_ov), 64'd1);
        check("def_y_not_yet", 64'(d_y), 64'd3);
        d_sel = 2'd1; tick(); check("def_y_sel0", 64'(d_y), 64'd1);
        d_sel = 2'd2; tick(); check("def_y_sel1", 64'(d_y), 64'd2);
        d_sel = 2'd3; tick(); check("def_y_sel2", 64'(d_y), 64'd3);
        tick();               check("def_y_sel3", 64'(d_y), 64'd4);
        check("def_sel_err", 64'(d_err), 64'd0);

        // PIPE=3: one-cycle valid pulse with ce toggling 1,0,1,0,1.
        p3_sel = 2'd1; p3_ce = 1'b1;
        p3_x = {18'h3, 18'h2, 18'h111, 18'h5};
        repeat (4) tick();
        check("p3_fill_y", 64'(p3_y), 64'h111);
        check("p3_fill_ov", 64'(p3_ov), 64'd0);
        p3_x = {18'h3, 18'h2, 18'h2AA, 18'h5}; p3_iv = 1'b1;
        tick(); check("p3_ov_e1", 64'(p3_ov), 64'd0);
        p3_x = {18'h3, 18'h2, 18'h3CC, 18'h5}; p3_iv = 1'b0; p3_ce = 1'b0;
        tick(); check("p3_ov_h1", 64'(p3_ov), 64'd0); check("p3_y_h1", 64'(p3_y), 64'h111);
        p3_ce = 1'b1;
        tick(); check("p3_ov_e2", 64'(p3_ov), 64'd0); check("p3_y_e2", 64'(p3_y), 64'h111);
        p3_ce = 1'b0;
        tick(); check("p3_ov_h2", 64'(p3_ov), 64'd0); check("p3_y_h2", 64'(p3_y), 64'h111);
        p3_ce = 1'b1;
        tick(); check("p3_ov_e3", 64'(p3_ov), 64'd1); check("p3_y_e3", 64'(p3_y), 64'h2AA);
        tick(); check("p3_ov_e4", 64'(p3_ov), 64'd0); check("p3_y_e4", 64'(p3_y), 64'h3CC);

        // NUM_CH=5, SEL_REG=0: out-of-range select and sticky flag rules.
        n5_x = {18'h55, 18'h44, 18'h33, 18'h22, 18'h11};
        n5_ce = 1'b1; n5_iv = 1'b1; n5_sel = 3'd7;
        tick();
        check("n5_y_oor", 64'(n5_y), 64'd0);
        check("n5_err_set", 64'(n5_err), 64'd1);
        check("n5_ov", 64'(n5_ov), 64'd1);
        n5_clr = 1'b1;
        tick(); check("n5_set_wins", 64'(n5_err), 64'd1);
        n5_sel = 3'd2;
        tick(); check("n5_err_clr", 64'(n5_err), 64'd0); check("n5_y_ch2", 64'(n5_y), 64'h33);
        n5_clr = 1'b0; n5_ce = 1'b0; n5_sel = 3'd7;
        tick(); check("n5_no_set_ce0", 64'(n5_err), 64'd0); check("n5_y_hold", 64'(n5_y), 64'h33);
        n5_ce = 1'b1;
        tick(); check("n5_err_reset", 64'(n5_err), 64'd1);
        n5_ce = 1'b0; n5_iv = 1'b0; n5_clr = 1'b1;
        tick(); check("n5_clr_no_ce", 64'(n5_err), 64'd0);
        n5_ce = 1'b1; n5_clr = 1'b0; n5_sel = 3'd6;
        tick(); check("n5_no_set_invalid", 64'(n5_err), 64'd0); check("n5_ov_low", 64'(n5_ov), 64'd0);

        // PIPE=2: asynchronous reset mid-stream.
        p2_x = {18'h7, 18'h2AB, 18'h9, 18'h123};
        p2_sel = 2'd2; p2_ce = 1'b1; p2_iv = 1'b1;
        repeat (5) tick();
        check("p2_stream_y", 64'(p2_y), 64'h2AB);
        check("p2_stream_ov", 64'(p2_ov), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("p2_rst_y", 64'(p2_y), 64'd0);
        check("p2_rst_ov", 64'(p2_ov), 64'd0);
        check("p2_rst_err", 64'(p2_err), 64'd0);
        tick();
        check("p2_rst_edge_ov", 64'(p2_ov), 64'd0);
        #2 rst = 1'b0;
        check("p2_rel_ov", 64'(p2_ov), 64'd0);
        tick(); check("p2_rel_ov_e1", 64'(p2_ov), 64'd0);
        tick(); check("p2_rel_ov_e2", 64'(p2_ov), 64'd1); check("p2_rel_y_e2", 64'(p2_y), 64'h123);
        tick(); check("p2_rel_y_e3", 64'(p2_y), 64'h2AB);

        // PIPE=0, SEL_REG=0: purely combinational path.
        for (int i = 0; i < 6; i++) begin
            p0_x   = 72'({$urandom, $urandom, $urandom});
            p0_sel = 2'($urandom);
            p0_iv  = 1'($urandom);
            #1;
            ep0 = 18'(p0_x >> (int'(p0_sel) * 18));
            check("p0_y", 64'(p0_y), 64'(ep0));
            check("p0_ov", 64'(p0_ov), 64'(p0_iv));
        end

        // Randomized sweep.
        rand_go = 1'b1;
        for (int i = 0; i < N_RAND + 200 && rnd_done < N_CFG; i++) @(posedge clk);
        check("rnd_done", 64'(rnd_done), 64'(N_CFG));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
